drive_ramp: RTL and testbench

Drive-level sequencer upstream of the SSB output stage. It takes an I/Q setpoint pair and produces the interleaved 18-bit `drive` word and the `enable` flag that the SSB stage consumes. A four-state machine ramps a 16-bit gain up or down at a programmable rate, so RF turn-on and turn-off are amplitude-limited rather than stepped. A `kill` input cuts drive immediately.

---
 rtl/drive_ramp.sv | 152 +++++++++++++++
 tb/tb_drive_ramp.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/drive_ramp.sv
// Drive-level sequencer: ramps a 16-bit gain up/down at a programmable rate
// and scales an I/Q setpoint pair into the interleaved SSB drive word.
module drive_ramp #(
    parameter int GW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           div_state,
    input  logic signed [17:0]   setp_i,
    input  logic signed [17:0]   setp_q,
    input  logic [GW-1:0]        ramp_step,
    input  logic                 rf_on,
    input  logic                 kill,
    output logic signed [17:0]   drive,
    output logic                 enable,
    output logic [1:0]           state,
    output logic [GW-1:0]        gain
);

    localparam int PW = 18 + GW + 1;
    localparam logic [GW-1:0] GMAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        FLAT = 2'd2,
        DOWN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        gain_q, gain_d;
    logic                 enable_q, enable_d;
    logic signed [17:0]   setpq_q;
    logic signed [17:0]   drive_q;
    logic signed [17:0]   prod_q;

    logic                 boundary;
    logic [GW:0]          up_sum;
    logic                 up_sat;
    logic                 dn_zero;
    state_t               up_state, dn_state;
    logic [GW-1:0]        up_gain, dn_gain;

    assign boundary = div_state[0];

    // Saturating step results, shared by every state that moves the gain.
    assign up_sum   = {1'b0, gain_q} + {1'b0, ramp_step};
    assign up_sat   = up_sum >= {1'b0, GMAX};
    assign up_state = up_sat ? FLAT : UP;
    assign up_gain  = up_sat ? GMAX : up_sum[GW-1:0];
    assign dn_zero  = ramp_step >= gain_q;
    assign dn_state = dn_zero ? IDLE : DOWN;
    assign dn_gain  = dn_zero ? '0 : gain_q - ramp_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gain_q   <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            enable_q <= enable_d;
        end
    end

    // Kill overrides everything and is honoured on any cycle.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        if (kill) begin
            state_d = IDLE;
            gain_d  = '0;
        end else if (boundary) begin
            case (state_q)
                IDLE: begin
                    if (rf_on) begin
                        state_d = up_state;
                        gain_d  = up_gain;
                    end else begin
                        gain_d = '0;
                    end
                end
                UP: begin
                    if (!rf_on) begin
                        state_d = DOWN;
                    end else begin
                        state_d = up_state;
                        gain_d  = up_gain;
                    end
                end
                FLAT: begin
                    if (!rf_on) begin
                        state_d = dn_state;
                        gain_d  = dn_gain;
                    end else begin
                        gain_d = GMAX;
                    end
                end
                DOWN: begin
                    if (rf_on) begin
                        state_d = UP;
                    end else begin
                        state_d = dn_state;
                        gain_d  = dn_gain;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gain_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        enable_d = (state_d != IDLE);
    end

    assign state  = state_q;
    assign gain   = gain_q;
    assign enable = enable_q;

    logic signed [17:0]   comp;
    logic signed [PW-1:0] comp_x, gain_x, prod_d;
    logic                 unused_bits;

    // I comes straight from the boundary-cycle input; Q from the copy taken
    // on that same edge, so both halves belong to one sampled pair.
    assign comp   = boundary ? setp_i : setpq_q;
    assign comp_x = PW'(comp);
    assign gain_x = PW'($signed({1'b0, gain_q}));
    assign prod_d = comp_x * gain_x;
    assign unused_bits = ^{prod_d[PW-1:GW+18], prod_d[GW-1:0], div_state[1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            setpq_q <= '0;
            prod_q  <= '0;
            drive_q <= '0;
        end else begin
            if (boundary) begin
                setpq_q <= setp_q;
            end
            prod_q  <= prod_d[GW+17:GW];
            drive_q <= prod_q;
        end
    end

    assign drive = drive_q;

endmodule

// File: tb/tb_drive_ramp.sv
// Bench for drive_ramp: a vector table covering ramp up, ramp down and
// reversal, then hand-written kill, step-0, setpoint-tear and reset sequences.
module tb_drive_ramp;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          div_state;
    logic signed [17:0]  setp_i, setp_q;
    logic [15:0]         ramp_step;
    logic                rf_on, kill;
    logic signed [17:0]  drive;
    logic                enable;
    logic [1:0]          state;
    logic [15:0]         gain;

    always #5 clk = ~clk;

    drive_ramp #(.GW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .div_state (div_state),
        .setp_i    (setp_i),
        .setp_q    (setp_q),
        .ramp_step (ramp_step),
        .rf_on     (rf_on),
        .kill      (kill),
        .drive     (drive),
        .enable    (enable),
        .state     (state),
        .gain      (gain)
    );

    typedef struct {
        logic        rf;
        logic        kl;
        logic [15:0] st;
        int          si;
        int          sq;
        int          es;
        logic [15:0] eg;
        logic        ee;
        logic        cd;
        int          ed;
    } vec_t;

    localparam int NV = 28;
    localparam int SI = 65536;
    localparam int SQ = -65536;

    vec_t tv[NV];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   k      = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        div_state = 2'(k);
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic check_sge(input string tag, input int es, input int eg, input int ee);
        check({tag, " state"},  int'(state),  es);
        check({tag, " gain"},   int'(gain),   eg);
        check({tag, " enable"}, int'(enable), ee);
    endtask

    initial begin
        // rf, kl, step, si, sq, exp state, exp gain, exp en, check drive, exp drive
        tv[0]  = '{1'b1, 1'b0, 16'h4000, SI, SQ, 0, 16'h0000, 1'b0, 1'b1, 0};
        tv[1]  = '{1'b1, 1'b0, 16'h4000, SI, SQ, 1, 16'h4000, 1'b1, 1'b1, 0};
        tv[2]  = '{1'b1, 1'b0, 16'h4000, SI, SQ, 1, 16'h4000, 1'b1, 1'b1, 0};
        tv[3]  = '{1'b1, 1'b0, 16'h4000, SI, SQ, 1, 16'h8000, 1'b1, 1'b1, -16384};
        tv[4]  = '{1'b1, 1'b0, 16'h4000, SI, SQ, 1, 16'h8000, 1'b1, 1'b1, 16384};
        tv[5]  = '{1'b1, 1'b0, 16'h4000, SI, SQ, 1, 16'hC000, 1'b1, 1'b1, -32768};
        tv[6]  = '{1'b1, 1'b0, 16'h4000, SI, SQ, 1, 16'hC000, 1'b1, 1'b1, 32768};
        tv[7]  = '{1'b1, 1'b0, 16'h4000, SI, SQ, 2, 16'hFFFF, 1'b1, 1'b1, -49152};
        tv[8]  = '{1'b1, 1'b0, 16'h4000, SI, SQ, 2, 16'hFFFF, 1'b1, 1'b1, 49152};
        tv[9]  = '{1'b1, 1'b0, 16'h4000, SI, SQ, 2, 16'hFFFF, 1'b1, 1'b1, -65535};
        tv[10] = '{1'b1, 1'b0, 16'h4000, SI, SQ, 2, 16'hFFFF, 1'b1, 1'b1, 65535};
        tv[11] = '{1'b0, 1'b0, 16'h8000, SI, SQ, 3, 16'h7FFF, 1'b1, 1'b1, -65535};
        tv[12] = '{1'b0, 1'b0, 16'h8000, SI, SQ, 3, 16'h7FFF, 1'b1, 1'b1, 65535};
        tv[13] = '{1'b0, 1'b0, 16'h8000, SI, SQ, 0, 16'h0000, 1'b0, 1'b1, -32767};
        tv[14] = '{1'b0, 1'b0, 16'h8000, SI, SQ, 0, 16'h0000, 1'b0, 1'b1, 32767};
        tv[15] = '{1'b0, 1'b0, 16'h8000, SI, SQ, 0, 16'h0000, 1'b0, 1'b1, 0};
        tv[16] = '{1'b0, 1'b0, 16'h8000, SI, SQ, 0, 16'h0000, 1'b0, 1'b1, 0};
        tv[17] = '{1'b1, 1'b0, 16'h4000, SI, SQ, 1, 16'h4000, 1'b1, 1'b0, 0};
        tv[18] = '{1'b1, 1'b0, 16'h4000, SI, SQ, 1, 16'h4000, 1'b1, 1'b0, 0};
        tv[19] = '{1'b1, 1'b0, 16'h4000, SI, SQ, 1, 16'h8000, 1'b1, 1'b0, 0};
        tv[20] = '{1'b0, 1'b0, 16'h4000, SI, SQ, 1, 16'h8000, 1'b1, 1'b0, 0};
        tv[21] = '{1'b0, 1'b0, 16'h4000, SI, SQ, 3, 16'h8000, 1'b1, 1'b0, 0};
        tv[22] = '{1'b0, 1'b0, 16'h4000, SI, SQ, 3, 16'h8000, 1'b1, 1'b0, 0};
        tv[23] = '{1'b0, 1'b0, 16'h4000, SI, SQ, 3, 16'h4000, 1'b1, 1'b0, 0};
        tv[24] = '{1'b1, 1'b0, 16'h4000, SI, SQ, 3, 16'h4000, 1'b1, 1'b0, 0};
        tv[25] = '{1'b1, 1'b0, 16'h4000, SI, SQ, 1, 16'h4000, 1'b1, 1'b0, 0};
        tv[26] = '{1'b1, 1'b0, 16'h4000, SI, SQ, 1, 16'h4000, 1'b1, 1'b0, 0};
        tv[27] = '{1'b1, 1'b0, 16'h4000, SI, SQ, 1, 16'h8000, 1'b1, 1'b0, 0};

        // Clock/reset
        rst = 1'b1; div_state = 2'd0; setp_i = '0; setp_q = '0;
        ramp_step = '0; rf_on = 1'b0; kill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_sge("reset", 0, 0, 0);
        check("reset drive", drive, 0);
        rst = 1'b0;
        k = 0;

        // Ramp up, ramp down, reversal
        for (int r = 0; r < NV; r++) begin
            rf_on = tv[r].rf; kill = tv[r].kl; ramp_step = tv[r].st;
            setp_i = 18'(tv[r].si); setp_q = 18'(tv[r].sq);
            tick();
            check_sge($sformatf("row%0d", r), tv[r].es, int'(tv[r].eg), int'(tv[r].ee));
            if (tv[r].cd) check($sformatf("row%0d drive", r), drive, tv[r].ed);
        end

        // Climb to FLAT, then a one-cycle kill on a non-boundary cycle
        rf_on = 1'b1; ramp_step = 16'h4000;
        repeat (4) tick();
        check_sge("pre-kill", 2, 16'hFFFF, 1);
        check("kill phase", k % 2, 0);
        kill = 1'b1;
        tick();
        check_sge("kill", 0, 0, 0);
        kill = 1'b0; rf_on = 1'b0;
        repeat (2) tick();
        check("kill drive", drive, 0);

        // Kill held against rf_on
        kill = 1'b1; rf_on = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_sge($sformatf("kill held %0d", i), 0, 0, 0);
        end

        // Step 0 enters UP but holds gain
        kill = 1'b0; ramp_step = 16'h0000;
        repeat (4) tick();
        check_sge("step0", 1, 0, 1);

        // Setpoint tear: change on a non-boundary cycle from FLAT
        kill = 1'b1; tick(); kill = 1'b0;
        ramp_step = 16'hFFFF; rf_on = 1'b1;
        setp_i = 18'sd65536; setp_q = -18'sd65536;
        if (k % 2 != 0) tick();
        repeat (6) tick();
        check_sge("tear pre", 2, 16'hFFFF, 1);
        setp_i = 18'sd131071; setp_q = -18'sd131072;
        tick();
        check("tear old I", drive, 65535);
        tick();
        check("tear old Q", drive, -65535);
        tick();
        check("tear new I", drive, 131069);
        tick();
        check("tear new Q", drive, -131070);

        // Async reset mid-ramp, then restart from zero
        kill = 1'b1; tick(); kill = 1'b0;
        rf_on = 1'b1; ramp_step = 16'h1000;
        repeat (6) tick();
        check("mid-ramp state", int'(state), 1);
        #3 rst = 1'b1;
        #1;
        check_sge("async rst", 0, 0, 0);
        check("async rst drive", drive, 0);
        rst = 1'b0;
        if (k % 2 == 0) begin
            tick();
            check_sge("post rst idle", 0, 0, 0);
        end
        tick();
        check_sge("post rst up", 1, 16'h1000, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
